blackbox_prober: RTL

- Sequential stimulus/capture stage wrapped around the Lab1 `blackbox` combinational cell (inputs e, u, a; output x).
- Drives all 8 input vectors {e,u,a} in order 0..7, samples x for each, and assembles an 8-bit truth table.
- Compares the table against an expected table and reports a mismatch flag and count.
- Sits directly upstream (feeds e/u/a) and downstream (consumes x) of the cell; used for self-check in lab harnesses.

---
 rtl/blackbox_prober.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/blackbox_prober.sv
// blackbox_prober
//   Sweeps all eight {e,u,a} input vectors of the Lab1 blackbox cell in order
//   0..7, samples the cell output x for each one and assembles an 8-bit truth
//   table. At the end of the sweep the table is published together with a
//   mismatch flag and an error count against an expected table.
//
//   `table` and `expect` are SystemVerilog keywords, so those two ports are
//   named truth_table and expected.
//
// Parameters
//   SETTLE      cycles each vector is held; x is sampled on the last one (1..15)
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   asynchronous, active-low
//   start        in   begin a sweep (looked at in IDLE only)
//   x_in         in   output x of the probed cell
//   expected     in   [7:0] expected table, bit i = x for vector i
//   e_out/u_out/a_out  out  cell inputs = idx[2]/idx[1]/idx[0] while running
//   busy         out  high for the whole sweep
//   done         out  one-cycle pulse after the sweep
//   truth_table  out  [7:0] captured table, bit i = x for vector i
//   valid        out  truth_table holds a complete sweep
//   mismatch     out  truth_table != expected for the last sweep
//   err_cnt      out  [3:0] popcount(truth_table ^ expected)
module blackbox_prober #(
  parameter int SETTLE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       x_in,
  input  logic [7:0] expected,
  output logic       e_out,
  output logic       u_out,
  output logic       a_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic       valid,
  output logic       mismatch,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] shadow;
  logic [7:0] shadow_nxt;
  logic       sample;
  logic       finish;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // The final bit is captured on the same edge that publishes the table, so
  // the published value is built from the shadow plus the bit being sampled.
  assign sample = (state == RUN) && (cnt == LAST);
  assign finish = sample && (idx == 3'd7);

  always_comb begin
    shadow_nxt = shadow;
    if (sample) begin
      shadow_nxt[idx] = x_in;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    e_out = 1'b0;
    u_out = 1'b0;
    a_out = 1'b0;
    case (state)
      RUN: begin
        busy  = 1'b1;
        e_out = idx[2];
        u_out = idx[1];
        a_out = idx[0];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Sweep counters, capture shadow and published results
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx         <= 3'd0;
      cnt         <= 4'd0;
      shadow      <= 8'd0;
      truth_table <= 8'd0;
      valid       <= 1'b0;
      mismatch    <= 1'b0;
      err_cnt     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= 3'd0;
            cnt   <= 4'd0;
            valid <= 1'b0;
          end
        end
        RUN: begin
          if (sample) begin
            shadow <= shadow_nxt;
            cnt    <= 4'd0;
            if (finish) begin
              truth_table <= shadow_nxt;
              valid       <= 1'b1;
              mismatch    <= (shadow_nxt != expected);
              err_cnt     <= popcount8(shadow_nxt ^ expected);
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
